// File: rtl/in_port_fifo.sv
// Input-port FIFO: synchronises an async device strobe, buffers 32-bit words and
// presents the head on BusMuxIn_InPort. Optional macro INPORT_OVF_COUNT_EN adds Ovf_Count.
module in_port_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clock,
    input  logic          Clear,
    input  logic [31:0]   Dev_Data,
    input  logic          Dev_Strobe,
    input  logic          InPort,
    input  logic          Ovf_Clr,
    output logic [31:0]   BusMuxIn_InPort,
    output logic          Empty,
    output logic          Full,
    output logic [AW:0]   Count,
    output logic          Overflow
`ifdef INPORT_OVF_COUNT_EN
    ,
    output logic [7:0]    Ovf_Count
`endif
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          s1, s2, s3;
    logic          InPort_d;
    logic          push_ev;
    logic          pop_ev;
    logic          do_push;
    logic          do_pop;
    logic          ovf_set;

    assign push_ev = s2 & ~s3;
    assign pop_ev  = InPort_d & ~InPort;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted
    // when it coincides with a real pop; a pop on empty is simply dropped.
    always_comb begin
        do_pop  = pop_ev & ~Empty;
        do_push = push_ev & (~Full | do_pop);
        ovf_set = push_ev & Full & ~do_pop;
    end

    assign Empty           = (Count == '0);
    assign Full            = (Count == FULL_COUNT);
    assign BusMuxIn_InPort = Empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            InPort_d <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            s1       <= Dev_Strobe;
            s2       <= s1;
            s3       <= s2;
            InPort_d <= InPort;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
            if (ovf_set)
                Overflow <= 1'b1;
            else if (Ovf_Clr)
                Overflow <= 1'b0;
        end
    end

    // Storage needs no reset: Empty masks stale contents on the bus.
    always_ff @(posedge Clock) begin
        if (Clear && do_push)
            mem[wr_ptr] <= Dev_Data;
    end

`ifdef INPORT_OVF_COUNT_EN
    always_ff @(posedge Clock) begin
        if (!Clear)
            Ovf_Count <= '0;
        else if (ovf_set && Ovf_Clr)
            Ovf_Count <= 8'd1;
        else if (Ovf_Clr)
            Ovf_Count <= '0;
        else if (ovf_set && (Ovf_Count != '1))
            Ovf_Count <= Ovf_Count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_in_port_fifo.sv
// Self-checking bench for in_port_fifo: table of operations with a queue scoreboard,
// plus hand sequences for simultaneous push/pop, clear priority and mid-operation reset.
module tb_in_port_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          Clock = 1'b0;
    logic          Clear;
    logic [31:0]   Dev_Data;
    logic          Dev_Strobe;
    logic          InPort;
    logic          Ovf_Clr;
    logic [31:0]   BusMuxIn_InPort;
    logic          Empty;
    logic          Full;
    logic [AW:0]   Count;
    logic          Overflow;
`ifdef INPORT_OVF_COUNT_EN
    logic [7:0]    Ovf_Count;
`endif

    in_port_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clock           (Clock),
        .Clear           (Clear),
        .Dev_Data        (Dev_Data),
        .Dev_Strobe      (Dev_Strobe),
        .InPort          (InPort),
        .Ovf_Clr         (Ovf_Clr),
        .BusMuxIn_InPort (BusMuxIn_InPort),
        .Empty           (Empty),
        .Full            (Full),
        .Count           (Count),
        .Overflow        (Overflow)
`ifdef INPORT_OVF_COUNT_EN
        ,
        .Ovf_Count       (Ovf_Count)
`endif
    );

    always #5 Clock = ~Clock;

    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_OVFCLR} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] data;
        int          hold;
        int          exp_count;
        logic        exp_ovf;
    } vec_t;

    int          tests  = 0;
    int          failed = 0;
    logic [31:0] sb_q[$];
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count/flags against a bench-side expected occupancy; bus against scoreboard head.
    task automatic chk_state(input string name, input int exp_count, input logic exp_ovf);
        logic [31:0] head;
        head = (sb_q.size() != 0) ? sb_q[0] : 32'h0;
        chk({name, ".count"}, 32'(Count), 32'(exp_count));
        chk({name, ".empty"}, 32'(Empty), 32'(exp_count == 0));
        chk({name, ".full"},  32'(Full),  32'(exp_count == DEPTH));
        chk({name, ".ovf"},   32'(Overflow), 32'(exp_ovf));
        chk({name, ".bus"},   BusMuxIn_InPort, head);
    endtask

    // Strobe rises at a negedge; the word lands at the 3rd rising edge.
    task automatic do_push(input logic [31:0] data, input logic clr_at_write);
        @(negedge Clock);
        Dev_Data   = data;
        Dev_Strobe = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        Ovf_Clr = clr_at_write;
        @(posedge Clock);
        #1;
        if (sb_q.size() < DEPTH)
            sb_q.push_back(data);
        @(negedge Clock);
        Dev_Strobe = 1'b0;
        Ovf_Clr    = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
    endtask

    task automatic do_pop(input int hold);
        logic [31:0] head;
        head = (sb_q.size() != 0) ? sb_q[0] : 32'h0;
        @(negedge Clock);
        InPort = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock);
            #1;
            chk("pop.hold_bus", BusMuxIn_InPort, head);
        end
        @(negedge Clock);
        InPort = 1'b0;
        @(posedge Clock);
        #1;
        if (sb_q.size() != 0)
            void'(sb_q.pop_front());
    endtask

    initial begin
        Clear      = 1'b0;
        Dev_Data   = '0;
        Dev_Strobe = 1'b0;
        InPort     = 1'b0;
        Ovf_Clr    = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk_state("reset", 0, 1'b0);
        @(negedge Clock);
        Clear = 1'b1;

        vecs.push_back('{OP_PUSH,   32'h0000_00A5, 0, 1, 1'b0});
        vecs.push_back('{OP_POP,    32'h0,         2, 0, 1'b0});
        vecs.push_back('{OP_PUSH,   32'h11,        0, 1, 1'b0});
        vecs.push_back('{OP_PUSH,   32'h22,        0, 2, 1'b0});
        vecs.push_back('{OP_PUSH,   32'h33,        0, 3, 1'b0});
        vecs.push_back('{OP_PUSH,   32'h44,        0, 4, 1'b0});
        vecs.push_back('{OP_PUSH,   32'h55,        0, 4, 1'b1});
        vecs.push_back('{OP_POP,    32'h0,         1, 3, 1'b1});
        vecs.push_back('{OP_POP,    32'h0,         3, 2, 1'b1});
        vecs.push_back('{OP_POP,    32'h0,         1, 1, 1'b1});
        vecs.push_back('{OP_POP,    32'h0,         1, 0, 1'b1});
        vecs.push_back('{OP_POP,    32'h0,         1, 0, 1'b1});
        vecs.push_back('{OP_OVFCLR, 32'h0,         0, 0, 1'b0});

        for (int v = 0; v < vecs.size(); v++) begin
            case (vecs[v].op)
                OP_PUSH: do_push(vecs[v].data, 1'b0);
                OP_POP:  do_pop(vecs[v].hold);
                default: begin
                    @(negedge Clock);
                    Ovf_Clr = 1'b1;
                    @(posedge Clock);
                    #1;
                    @(negedge Clock);
                    Ovf_Clr = 1'b0;
                end
            endcase
            chk_state($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_ovf);
        end

        // Simultaneous push and pop while full: push accepted, no overflow.
        do_push(32'h11, 1'b0);
        do_push(32'h22, 1'b0);
        do_push(32'h33, 1'b0);
        do_push(32'h44, 1'b0);
        chk_state("full4", 4, 1'b0);
        @(negedge Clock);
        Dev_Data   = 32'h66;
        Dev_Strobe = 1'b1;
        InPort     = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        InPort = 1'b0;
        @(posedge Clock);
        #1;
        void'(sb_q.pop_front());
        sb_q.push_back(32'h66);
        chk_state("simul", 4, 1'b0);
        @(negedge Clock);
        Dev_Strobe = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            do_pop(1);
            chk_state($sformatf("simul_drain%0d", i), 3 - i, 1'b0);
        end

        // Ovf_Clr coincident with an overflowing push: set wins, then clear alone.
        for (int i = 0; i < 4; i++)
            do_push(32'hC0 + 32'(i), 1'b0);
        do_push(32'hDEAD, 1'b1);
        chk_state("clr_vs_set", 4, 1'b1);
        @(negedge Clock);
        Ovf_Clr = 1'b1;
        @(posedge Clock);
        #1;
        chk("clr_alone.ovf", 32'(Overflow), 32'h0);
        @(negedge Clock);
        Ovf_Clr = 1'b0;

        // Mid-operation reset with Overflow set and a strobe edge in flight.
        do_push(32'hBEEF, 1'b0);
        do_pop(1);
        chk_state("pre_reset", 3, 1'b1);
        @(negedge Clock);
        Dev_Strobe = 1'b1;
        Dev_Data   = 32'h77;
        @(posedge Clock);
        @(negedge Clock);
        Clear      = 1'b0;
        Dev_Strobe = 1'b0;
        @(posedge Clock);
        #1;
        sb_q.delete();
        chk_state("mid_reset", 0, 1'b0);
        @(negedge Clock);
        Clear = 1'b1;
        repeat (4) @(posedge Clock);
        #1;
        chk_state("no_ghost_push", 0, 1'b0);

        // Strobe held high yields a single push.
        @(negedge Clock);
        Dev_Data   = 32'h99;
        Dev_Strobe = 1'b1;
        repeat (8) @(posedge Clock);
        #1;
        sb_q.push_back(32'h99);
        chk_state("held_strobe", 1, 1'b0);
        @(negedge Clock);
        Dev_Strobe = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/in_port_fifo.md
Name: in_port_fifo

Overview:
Input-port stage upstream of the datapath's InPort bus source. Captures 32-bit words from an external device through an asynchronous strobe, buffers them in a small FIFO, and presents the head word on BusMuxIn_InPort for the "in Ra" instruction. Each InPort assertion consumes exactly one word, popped after the assertion ends, so the word stays stable for the whole T3 window regardless of how many cycles InPort is held.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
AW, 2, pointer width = log2(DEPTH)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Clear  input  1  synchronous active-low reset
Dev_Data  input  32  external device data; stable from Dev_Strobe rise until 3 Clock edges later
Dev_Strobe  input  1  asynchronous device strobe; one word per rising edge
InPort  input  1  datapath select of input port onto bus (level, may be held >= 1 cycle)
Ovf_Clr  input  1  clears Overflow sticky flag
BusMuxIn_InPort  output  32  head word; 32'h0 when empty
Empty  output  1  FIFO empty
Full  output  1  FIFO full
Count  output  AW+1  occupancy, 0..DEPTH
Overflow  output  1  sticky: push attempted while full

Behaviour:
- Reset (Clear=0 at posedge): rd_ptr=wr_ptr=0, Count=0, Empty=1, Full=0, Overflow=0, sync regs s1/s2/s3=0, InPort_d=0; BusMuxIn_InPort=0. Reset mid-transfer discards all buffered words and any in-flight strobe edge.
- Strobe sync: s1<=Dev_Strobe, s2<=s1, s3<=s2. push_ev = s2 & ~s3. Word written at the posedge where push_ev=1, i.e. 3rd rising edge after strobe rises; Dev_Data sampled directly at that edge.
- Pop: InPort_d<=InPort; pop_ev = InPort_d & ~InPort (falling edge). Pop at first posedge with InPort low after an assertion. The head does not change while InPort is high.
- Push when not full: mem[wr_ptr]<=Dev_Data, wr_ptr+1 mod DEPTH, Count+1.
- Push when full with no simultaneous pop: word dropped, Overflow<=1, pointers unchanged.
- Pop when empty: ignored, no state change.
- Push and pop in the same cycle: both performed, Count unchanged. This applies even when full: the push is accepted and Overflow is not set. When empty, the push proceeds and the pop is ignored.
- Ovf_Clr=1: Overflow<=0. If an overflow set occurs in the same cycle, set wins.
- BusMuxIn_InPort = Empty ? 0 : mem[rd_ptr]. Combinational from registers; valid the cycle after the write.
- Empty = (Count==0); Full = (Count==DEPTH); both derived from the registered Count.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH or goes below 0.
- Strobe held high produces one push only. A new word requires Dev_Strobe low for >= 1 Clock sample.

Optional Feature:
INPORT_OVF_COUNT_EN
- Defined: adds output Ovf_Count[7:0], which increments on each dropped word, saturates at 8'hFF, resets to 0, and is cleared by Ovf_Clr. If clear and increment occur in the same cycle, the result is 1.
- Undefined: Ovf_Count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then push: Clear=0 for 2 cycles, release; Dev_Data=32'h0000_00A5, strobe rises. Expect Count 0->1 at 3rd edge, Empty=0, BusMuxIn_InPort=32'h0000_00A5.
- Hold stability: InPort high for 2 cycles with head 32'h0000_00A5. Bus stays 32'h0000_00A5 throughout; pop occurs at the first edge after InPort falls; Empty=1 and bus=0 afterwards.
- Fill and overflow (DEPTH=4): push 32'h11, 32'h22, 32'h33, 32'h44. Full=1. Push 32'h55: Overflow=1, Count=4. Four InPort pulses read 11,22,33,44 in order; Empty=1.
- Simultaneous push/pop when full: push_ev and pop_ev in the same cycle with Count=4 and head 32'h11. Count stays 4, new head 32'h22, newest entry is the pushed word, Overflow unchanged at 0.
- Empty pop and clear priority: InPort pulse when empty leaves Count=0. Ovf_Clr=1 coincident with an overflowing push leaves Overflow=1; Ovf_Clr alone the next cycle gives Overflow=0.
- Mid-operation reset: Count=3, Clear=0 for 1 edge. Count=0, Empty=1, Overflow=0, bus=0. A strobe edge pending in s1/s2 at reset time causes no push.
